// File: rtl/dma_channel_arbiter_pkg.sv
// Shared types and constants for the DMA channel arbiter slice.
// Optional feature macro used by this slice: DMA_ARB_HOLD_TIMEOUT_EN.
package dma_reg_pkg;

  localparam int unsigned NUM_DMA_CH = 4;
  localparam int unsigned CH_IDX_W   = 2;
  localparam int unsigned HOLD_CNT_W = 8;

  typedef enum logic [1:0] {
    ARB_IDLE     = 2'd0,
    ARB_HOLD_REQ = 2'd1,
    ARB_ACTIVE   = 2'd2,
    ARB_RELEASE  = 2'd3
  } arb_state_t;

  // Channel index to one-hot acknowledge vector (active-high form).
  function automatic logic [NUM_DMA_CH-1:0] ch_onehot(input logic [CH_IDX_W-1:0] ch);
    ch_onehot = NUM_DMA_CH'(1) << ch;
  endfunction

endpackage

// File: rtl/dma_channel_arbiter_if.sv
// Request/grant bundle between register file, arbiter and CPU hold logic.
interface dma_channel_arbiter_if;
  import dma_reg_pkg::*;

  logic [NUM_DMA_CH-1:0] dreq;
  logic                  dreq_sense;
  logic                  dack_sense;
  logic                  priority_type;
  logic                  dma_en;
  logic [NUM_DMA_CH-1:0] mask;
  logic [NUM_DMA_CH-1:0] sw_req;
  logic                  hlda;
  logic                  svc_done;
  logic                  hrq;
  logic [NUM_DMA_CH-1:0] dack;
  logic                  grant_vld;
  logic [CH_IDX_W-1:0]   grant_ch;
  logic [NUM_DMA_CH-1:0] req_status;
  logic                  hold_err;

  modport master (
    output dreq, dreq_sense, dack_sense, priority_type, dma_en, mask, sw_req, hlda, svc_done,
    input  hrq, dack, grant_vld, grant_ch, req_status, hold_err
  );

  modport slave (
    input  dreq, dreq_sense, dack_sense, priority_type, dma_en, mask, sw_req, hlda, svc_done,
    output hrq, dack, grant_vld, grant_ch, req_status, hold_err
  );

endinterface

// File: rtl/dma_channel_arbiter_prio_encoder.sv
// Combinational rotating-priority encoder: first set request at or above the pointer, mod 4.
module dma_prio_encoder
  import dma_reg_pkg::*;
(
  input  logic [NUM_DMA_CH-1:0] req_i,
  input  logic [CH_IDX_W-1:0]   ptr_i,
  output logic [CH_IDX_W-1:0]   win_o,
  output logic                  vld_o
);

  // Scan from the farthest offset down so the nearest offset to the pointer wins.
  always_comb begin
    win_o = '0;
    vld_o = 1'b0;
    for (int k = NUM_DMA_CH - 1; k >= 0; k--) begin
      if (req_i[ptr_i + CH_IDX_W'(k)]) begin
        win_o = ptr_i + CH_IDX_W'(k);
        vld_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dma_channel_arbiter.sv
// Four-channel DREQ arbiter and bus-hold sequencer (8237A style).
// Optional: define DMA_ARB_HOLD_TIMEOUT_EN to abandon an unanswered HRQ after
// HLDA_TIMEOUT cycles and raise the sticky hold_err flag.
module dma_channel_arbiter
  import dma_reg_pkg::*;
#(
  parameter int unsigned NUM_CH       = NUM_DMA_CH,
  parameter int unsigned HLDA_TIMEOUT = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  dma_channel_arbiter_if.slave  arb_if
);

  logic [NUM_CH-1:0]   req_eff_c;
  logic [NUM_CH-1:0]   req_q;
  logic [NUM_CH-1:0]   grant_oh_q;
  logic [CH_IDX_W-1:0] grant_ch_q;
  logic [CH_IDX_W-1:0] ptr_q;
  logic [CH_IDX_W-1:0] arb_ptr_c;
  logic [CH_IDX_W-1:0] win_c;
  logic                win_vld_c;
  logic                hrq_q;
  logic                grant_vld_q;
  logic                hold_err_q;
  logic                hold_to_c;
  arb_state_t          state_q;

  // Software requests bypass the mask; hardware requests are polarity-corrected first.
  assign req_eff_c = ((arb_if.dreq ^ {NUM_CH{arb_if.dreq_sense}}) & ~arb_if.mask) | arb_if.sw_req;

  // Fixed mode always scans from channel 0, even before the pointer register catches up.
  assign arb_ptr_c = arb_if.priority_type ? ptr_q : '0;

  dma_prio_encoder u_prio (
    .req_i (req_q),
    .ptr_i (arb_ptr_c),
    .win_o (win_c),
    .vld_o (win_vld_c)
  );

`ifdef DMA_ARB_HOLD_TIMEOUT_EN
  logic [HOLD_CNT_W-1:0] hold_cnt_q;

  assign hold_to_c = (hold_cnt_q == HOLD_CNT_W'(HLDA_TIMEOUT - 1));

  // Count cycles spent waiting for HLDA; cleared whenever not in HOLD_REQ.
  always_ff @(posedge clk) begin
    if (reset || (state_q != ARB_HOLD_REQ)) begin
      hold_cnt_q <= '0;
    end else if (!hold_to_c) begin
      hold_cnt_q <= hold_cnt_q + HOLD_CNT_W'(1);
    end
  end
`else
  logic unused_hlda_timeout;

  assign hold_to_c           = 1'b0;
  assign unused_hlda_timeout = ^HOLD_CNT_W'(HLDA_TIMEOUT);
`endif

  // Request capture, hold/grant sequencing and priority pointer update.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ARB_IDLE;
      req_q       <= '0;
      hrq_q       <= 1'b0;
      grant_vld_q <= 1'b0;
      grant_ch_q  <= '0;
      grant_oh_q  <= '0;
      ptr_q       <= '0;
      hold_err_q  <= 1'b0;
    end else begin
      req_q <= req_eff_c;
      if (!arb_if.priority_type) begin
        ptr_q <= '0;
      end
      case (state_q)
        ARB_IDLE: begin
          if (arb_if.dma_en && (|req_q)) begin
            state_q <= ARB_HOLD_REQ;
            hrq_q   <= 1'b1;
          end
        end
        ARB_HOLD_REQ: begin
          if (!arb_if.dma_en || !(|req_q)) begin
            state_q <= ARB_IDLE;
            hrq_q   <= 1'b0;
          end else if (arb_if.hlda && win_vld_c) begin
            state_q     <= ARB_ACTIVE;
            grant_ch_q  <= win_c;
            grant_oh_q  <= ch_onehot(win_c);
            grant_vld_q <= 1'b1;
          end else if (hold_to_c) begin
            state_q    <= ARB_IDLE;
            hrq_q      <= 1'b0;
            hold_err_q <= 1'b1;
          end
        end
        ARB_ACTIVE: begin
          if (arb_if.svc_done) begin
            state_q     <= ARB_RELEASE;
            hrq_q       <= 1'b0;
            grant_vld_q <= 1'b0;
            grant_ch_q  <= '0;
            grant_oh_q  <= '0;
            if (arb_if.priority_type) begin
              ptr_q <= grant_ch_q + CH_IDX_W'(1);
            end
          end
        end
        ARB_RELEASE: begin
          if (!arb_if.hlda) begin
            state_q <= ARB_IDLE;
          end
        end
        default: begin
          state_q <= ARB_IDLE;
        end
      endcase
    end
  end

  assign arb_if.hrq        = hrq_q;
  assign arb_if.grant_vld  = grant_vld_q;
  assign arb_if.grant_ch   = grant_ch_q;
  assign arb_if.req_status = req_q;
  assign arb_if.hold_err   = hold_err_q;
  assign arb_if.dack       = arb_if.dack_sense ? grant_oh_q : ~grant_oh_q;

endmodule

// File: tb/tb_dma_channel_arbiter.sv
// Self-checking bench for dma_channel_arbiter: directed scenarios plus randomized
// transactions checked against a request/pointer reference model.
module tb_dma_channel_arbiter;
  import dma_reg_pkg::*;

`ifdef DMA_ARB_HOLD_TIMEOUT_EN
  localparam int unsigned TO_CYC = 8;
`else
  localparam int unsigned TO_CYC = 64;
`endif

  logic clk;
  logic reset;
  int   checks    = 0;
  int   failures  = 0;
  int   model_ptr = 0;

  dma_channel_arbiter_if ifc ();

  dma_channel_arbiter #(
    .NUM_CH       (4),
    .HLDA_TIMEOUT (TO_CYC)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .arb_if (ifc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: effective request per channel from the raw inputs.
  function automatic logic [3:0] model_eff(input logic [3:0] d, input logic ds,
                                           input logic [3:0] m, input logic [3:0] s);
    logic [3:0] e;
    bit hw;
    for (int i = 0; i < 4; i++) begin
      hw   = ds ? (d[i] == 1'b0) : (d[i] == 1'b1);
      e[i] = (hw && !m[i]) || s[i];
    end
    return e;
  endfunction

  // Reference: first requesting channel walking upward from the pointer.
  function automatic int model_winner(input logic [3:0] eff, input int ptr);
    for (int k = 0; k < 4; k++) begin
      if (eff[(ptr + k) % 4]) return (ptr + k) % 4;
    end
    return -1;
  endfunction

  function automatic logic [3:0] model_dack(input int ch, input logic sense, input bit vld);
    logic [3:0] oh;
    oh = vld ? (4'b0001 << ch) : 4'b0000;
    return sense ? oh : ~oh;
  endfunction

  task automatic wait_hrq(input string tag);
    int n;
    n = 0;
    while ((ifc.hrq !== 1'b1) && (n < 20)) begin
      tick();
      n++;
    end
    chk(tag, 32'(ifc.hrq), 32'd1);
  endtask

  // One full hold/grant/service/release transaction.
  task automatic serve(input string tag, input int dly, input int exp_ch, input logic [3:0] exp_status);
    logic [3:0] save_mask;
    logic       save_en;
    wait_hrq({tag, "_hrq"});
    chk({tag, "_status"}, 32'(ifc.req_status), 32'(exp_status));
    ifc.svc_done = 1'b1;
    tick();
    ifc.svc_done = 1'b0;
    tick(dly);
    chk({tag, "_pre_grant"}, 32'(ifc.grant_vld), 32'd0);
    ifc.hlda = 1'b1;
    tick();
    chk({tag, "_grant_vld"}, 32'(ifc.grant_vld), 32'd1);
    chk({tag, "_grant_ch"}, 32'(ifc.grant_ch), 32'(exp_ch));
    chk({tag, "_dack"}, 32'(ifc.dack), 32'(model_dack(exp_ch, ifc.dack_sense, 1'b1)));
    save_mask  = ifc.mask;
    save_en    = ifc.dma_en;
    ifc.mask   = 4'hF;
    ifc.dma_en = 1'b0;
    tick(2);
    chk({tag, "_held"}, 32'({ifc.grant_vld, ifc.grant_ch, ifc.hrq}), 32'({1'b1, 2'(exp_ch), 1'b1}));
    ifc.mask     = save_mask;
    ifc.dma_en   = save_en;
    ifc.svc_done = 1'b1;
    tick();
    ifc.svc_done = 1'b0;
    chk({tag, "_rel"}, 32'({ifc.hrq, ifc.grant_vld}), 32'd0);
    chk({tag, "_rel_dack"}, 32'(ifc.dack), 32'(model_dack(0, ifc.dack_sense, 1'b0)));
    tick(2);
    chk({tag, "_rel_wait"}, 32'(ifc.hrq), 32'd0);
    ifc.hlda = 1'b0;
    tick();
    model_ptr = ifc.priority_type ? (exp_ch + 1) % 4 : 0;
  endtask

  task automatic set_idle();
    ifc.dreq   = {4{ifc.dreq_sense}};
    ifc.sw_req = 4'h0;
    tick(3);
  endtask

  initial begin
    int n;
    ifc.dreq          = 4'h0;
    ifc.dreq_sense    = 1'b0;
    ifc.dack_sense    = 1'b0;
    ifc.priority_type = 1'b0;
    ifc.dma_en        = 1'b1;
    ifc.mask          = 4'h0;
    ifc.sw_req        = 4'h0;
    ifc.hlda          = 1'b0;
    ifc.svc_done      = 1'b0;
    reset             = 1'b1;
    tick(2);
    chk("rst_hrq", 32'(ifc.hrq), 32'd0);
    chk("rst_grant_vld", 32'(ifc.grant_vld), 32'd0);
    chk("rst_grant_ch", 32'(ifc.grant_ch), 32'd0);
    chk("rst_dack", 32'(ifc.dack), 32'hF);
    chk("rst_status", 32'(ifc.req_status), 32'd0);
    chk("rst_hold_err", 32'(ifc.hold_err), 32'd0);
    reset = 1'b0;
    tick();

    // Fixed priority: ch1 beats ch3, and wins again on re-arbitration.
    ifc.dreq = 4'b1010;
    serve("fixed1", 2, 1, 4'b1010);
    serve("fixed2", 2, 1, 4'b1010);
    set_idle();

    // Rotating priority: all channels requesting, order walks and wraps.
    ifc.priority_type = 1'b1;
    ifc.dreq          = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      serve("rot", 1, i % 4, 4'hF);
    end
    set_idle();

    // Mask blocks hardware requests but not software requests.
    ifc.priority_type = 1'b0;
    model_ptr         = 0;
    ifc.mask          = 4'hF;
    ifc.dreq          = 4'hF;
    ifc.sw_req        = 4'b0100;
    serve("mask_sw", 2, 2, 4'b0100);
    ifc.dreq = 4'h0;
    set_idle();
    ifc.mask = 4'h0;

    // Active-low DREQ pulse without HLDA: HRQ rises then withdraws.
    ifc.dreq_sense = 1'b1;
    ifc.dreq       = 4'b1110;
    tick(2);
    chk("wd_hrq_up", 32'(ifc.hrq), 32'd1);
    ifc.dreq = 4'b1111;
    tick(2);
    chk("wd_hrq_down", 32'(ifc.hrq), 32'd0);
    tick(2);
    chk("wd_hrq_stay", 32'(ifc.hrq), 32'd0);
    ifc.dack_sense = 1'b1;
    ifc.dreq       = 4'b1110;
    serve("dack_hi", 2, 0, 4'b0001);
    set_idle();
    ifc.dreq_sense = 1'b0;
    ifc.dreq       = 4'h0;
    ifc.dack_sense = 1'b0;
    tick(3);

    // Reset while ch3 is granted with the rotating pointer at 2.
    ifc.priority_type = 1'b1;
    ifc.dreq          = 4'b0010;
    serve("rst_pre", 1, 1, 4'b0010);
    set_idle();
    ifc.dreq = 4'b1000;
    wait_hrq("rst_mid_hrq");
    ifc.hlda = 1'b1;
    tick();
    chk("rst_mid_grant", 32'({ifc.grant_vld, ifc.grant_ch}), 32'({1'b1, 2'd3}));
    reset    = 1'b1;
    ifc.hlda = 1'b0;
    ifc.dreq = 4'hF;
    tick();
    chk("rst_mid_out", 32'({ifc.hrq, ifc.grant_vld, ifc.grant_ch}), 32'd0);
    chk("rst_mid_dack", 32'(ifc.dack), 32'hF);
    reset     = 1'b0;
    model_ptr = 0;
    serve("rst_post", 1, 0, 4'hF);
    set_idle();
    ifc.priority_type = 1'b0;
    model_ptr         = 0;
    tick(2);

`ifdef DMA_ARB_HOLD_TIMEOUT_EN
    // HLDA never arrives: HRQ is abandoned and hold_err sticks.
    ifc.dreq = 4'b0001;
    wait_hrq("to_hrq");
    n = 0;
    while ((ifc.hrq === 1'b1) && (n < 100)) begin
      n++;
      tick();
    end
    chk("to_hrq_cycles", 32'(n), 32'(TO_CYC));
    chk("to_hold_err", 32'(ifc.hold_err), 32'd1);
    tick();
    chk("to_rereq", 32'(ifc.hrq), 32'd1);
    ifc.dreq = 4'h0;
    tick(TO_CYC + 5);
    chk("to_sticky", 32'(ifc.hold_err), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("to_clear", 32'(ifc.hold_err), 32'd0);
    tick();
`else
    // Without the timeout, HOLD_REQ waits as long as it takes.
    ifc.dreq = 4'b0001;
    wait_hrq("nto_hrq");
    tick(TO_CYC + 10);
    chk("nto_still_hrq", 32'(ifc.hrq), 32'd1);
    chk("nto_hold_err", 32'(ifc.hold_err), 32'd0);
    serve("nto_serve", 2, 0, 4'b0001);
    ifc.dreq = 4'h0;
    tick(3);
`endif

    // Randomized transactions against the reference model.
    for (int it = 0; it < 40; it++) begin
      logic [3:0] d;
      logic [3:0] m;
      logic [3:0] s;
      logic       ds;
      logic       pt;
      logic       en;
      logic [3:0] eff;
      d  = 4'($urandom_range(0, 15));
      m  = 4'($urandom_range(0, 15));
      s  = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'h0;
      ds = 1'($urandom_range(0, 1));
      pt = 1'($urandom_range(0, 1));
      en = ($urandom_range(0, 7) != 0);
      if (!pt) model_ptr = 0;
      eff               = model_eff(d, ds, m, s);
      ifc.dreq          = d;
      ifc.mask          = m;
      ifc.sw_req        = s;
      ifc.dreq_sense    = ds;
      ifc.priority_type = pt;
      ifc.dma_en        = en;
      ifc.dack_sense    = 1'($urandom_range(0, 1));
      if (en && (eff != 4'h0)) begin
        serve("rand", $urandom_range(1, 4), model_winner(eff, model_ptr), eff);
      end else begin
        tick(4);
        chk("rand_no_hrq", 32'(ifc.hrq), 32'd0);
        chk("rand_status", 32'(ifc.req_status), 32'(eff));
      end
      set_idle();
      ifc.dma_en = 1'b1;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dma_channel_arbiter.md
Name: dma_channel_arbiter

Overview:
Four-channel DREQ arbiter and bus-hold sequencer for the 8237A-style DMA controller. It merges hardware DREQ and software request bits, applies mask and command-register controls, and raises HRQ to the CPU. On HLDA it grants exactly one channel, drives DACK, and holds the grant until the transfer engine signals service complete. It sits between the register file (command/mask/request registers) and the transfer timing engine.

Parameters:
NUM_CH, 4, number of DMA channels (fixed at 4; grant_ch is 2 bits)
HLDA_TIMEOUT, 64, cycles HRQ may wait for HLDA (used only with the optional feature)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
dreq  in  4  raw hardware channel requests
dreq_sense  in  1  CMD_REG[6]; 0 = DREQ active-high, 1 = active-low
dack_sense  in  1  CMD_REG[7]; 0 = DACK active-low, 1 = active-high
priority_type  in  1  CMD_REG[4]; 0 = fixed (ch0 highest), 1 = rotating
dma_en  in  1  controller enable (CMD_REG[2] decoded active)
mask  in  4  MASK_REG[3:0]; 1 = channel hardware request masked
sw_req  in  4  software request bits, decoded per channel from REQ_REG
hlda  in  1  hold acknowledge from CPU
svc_done  in  1  one-cycle pulse from the transfer engine: current service finished
hrq  out  1  hold request to CPU
dack  out  4  channel acknowledge, polarity per dack_sense
grant_vld  out  1  a channel is currently granted
grant_ch  out  2  granted channel index
req_status  out  4  registered effective requests (STATUS_REG[7:4])
hold_err  out  1  HLDA timeout flag (optional feature only, else tied 0)

Behaviour:
- Effective request: req_eff[i] = ((dreq[i] ^ dreq_sense) & ~mask[i]) | sw_req[i]. Software requests ignore mask. req_eff is registered into req_q every cycle, giving 1 cycle of latency; req_status = req_q.
- States are IDLE, HOLD_REQ, ACTIVE and RELEASE. Reset: state = IDLE, hrq = 0, grant_vld = 0, grant_ch = 0, onehot grant = 0, priority pointer = 0, hold_err = 0.
- dack = dack_sense ? grant_onehot : ~grant_onehot. After reset with dack_sense = 0, dack = 4'b1111.
- IDLE -> HOLD_REQ when dma_en && |req_q. hrq goes to 1 on the same edge.
- HOLD_REQ: hrq = 1.
  - If req_q becomes 0 or dma_en = 0 before hlda, go to IDLE and drop hrq.
  - If hlda = 1, arbitrate on req_q, latch grant_ch and the onehot grant, set grant_vld, and go to ACTIVE. dack is valid the cycle after hlda is sampled.
- Arbitration: the winner is the first set req_q bit scanning upward from the pointer, mod 4. In fixed mode the pointer is held at 0.
- ACTIVE: the grant is held regardless of dreq, mask, or dma_en changes. A new request never preempts the current grant.
  - On svc_done: clear the grant and grant_vld, drop hrq, and go to RELEASE.
  - In rotating mode, set the pointer to grant_ch + 1 (2-bit wrap, so ch3 -> 0).
- RELEASE: wait for hlda = 0, then go to IDLE. A new HRQ therefore never overlaps a stale HLDA.
- priority_type changing 1 -> 0 forces the pointer to 0 on the next edge.
- svc_done outside ACTIVE is ignored. hlda in IDLE is ignored.
- Reset asserted in any state returns all outputs to their reset values on that edge. No partial grant survives.

Optional Feature:
DMA_ARB_HOLD_TIMEOUT_EN
- Defined: an 8-bit counter runs in HOLD_REQ.
  - If HLDA_TIMEOUT cycles elapse without hlda, drop hrq, set hold_err (sticky until reset), and go to IDLE.
  - Re-request is allowed after 1 idle cycle.
- Undefined: no counter, HOLD_REQ waits indefinitely, hold_err = 0.

Decomposition:
- dma_reg_pkg gains arb_state_t (2-bit enum of the four states) and the constant NUM_DMA_CH = 4.
- One sub-module: dma_prio_encoder, a combinational 4-bit request plus 2-bit pointer -> 2-bit winner and valid flag. It is instantiated once.

Test Plan:
- Fixed priority:
  - Stimulus: priority_type = 0, dreq = 4'b1010, mask = 0, hlda raised 3 cycles after hrq.
  - Required: grant_ch = 1; dack = 4'b1101 (dack_sense = 0).
  - Then svc_done and hlda dropped; on re-arb with dreq held, ch1 wins again.
- Rotating priority:
  - Stimulus: priority_type = 1, dreq = 4'b1111, four full grant/svc_done/hlda cycles.
  - Required: grant order 0, 1, 2, 3, with the pointer wrapping to 0.
- Mask vs software request:
  - Stimulus: mask = 4'b1111, dreq = 4'b1111, sw_req = 4'b0100.
  - Required: only ch2 is granted; req_status = 4'b0100.
- Request withdrawal and sense polarity:
  - Stimulus: dreq_sense = 1 and dreq pulses 4'b1110 (ch0 active) for 2 cycles, with no hlda.
  - Required: hrq rises, then falls back in IDLE. Repeat with dack_sense = 1: the granted channel drives dack = 4'b0001.
- Reset mid-operation:
  - Stimulus: reset during ACTIVE with grant_ch = 3.
  - Required: next cycle hrq = 0, grant_vld = 0, pointer = 0, dack = 4'b1111.
- Timeout (macro defined, HLDA_TIMEOUT = 8):
  - Stimulus: hlda held low.
  - Required: hrq drops after 8 cycles, hold_err = 1 and stays 1 until reset.
